bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  WIDTH  8  parallel word width, 2..32
  MSB_FIRST  1  1 = bit WIDTH-1 shifted first, 0 = bit 0 first
  IDLE_BIT  0  ser_out level when no valid bit is driven
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning (clock and reset first):
  clk  input  1  single clock, rising edge
  rst  input  1  asynchronous, active-high reset
  din  input  WIDTH  parallel word
  din_valid  input  1  din holds a word
  din_ready  output  1  block can accept a word this cycle
  ser_out  output  1  serial bit to the downstream bit-stream consumer
  ser_valid  output  1  ser_out carries a data bit
  frame_start  output  1  ser_out is the first bit of a word
  busy  output  1  shifter or hold buffer occupied

Function
REQ-003 A word SHALL be accepted on a rising edge where din_valid and din_ready are both 1; din_valid without din_ready SHALL have no effect.
REQ-004 The block SHALL hold at most two words: one in the shift register and one in a one-entry hold buffer.
REQ-005 din_ready SHALL equal NOT hold_full, forced to 0 while rst is 1.
REQ-006 The state machine SHALL have two states, IDLE and SHIFT, with a bit counter of $clog2(WIDTH) bits.
REQ-007 IDLE: if a word is accepted at edge N, it SHALL load the shifter directly, go to SHIFT, and drive its first bit on cycle N+1 with ser_valid=1 and frame_start=1.
REQ-008 SHIFT SHALL drive one bit per cycle for WIDTH consecutive cycles, in the order set by MSB_FIRST, with frame_start=0 after the first bit.
REQ-009 Acceptance in SHIFT before the last-bit cycle SHALL write the word into the hold buffer.
REQ-010 At the edge that ends the last-bit cycle, the next word SHALL be selected in priority order: hold buffer (buffer empties), then a word accepted at that same edge (direct load), otherwise transition to IDLE.
REQ-011 Back-to-back words SHALL stream with zero gap cycles: sustained throughput of one word per WIDTH cycles.
REQ-012 Hold buffer full with no free slot: din_ready=0; din SHALL NOT be sampled; din_ready SHALL return to 1 on the cycle after the buffer drains.
REQ-013 When ser_valid=0, ser_out SHALL equal IDLE_BIT and frame_start SHALL be 0.
REQ-014 busy SHALL be 1 in SHIFT or when the hold buffer is full, otherwise 0.
REQ-015 ser_out, ser_valid and frame_start SHALL be registered outputs, with no combinational path from din or din_valid.

Reset
REQ-016 While rst=1: state=IDLE, counter=0, shifter and hold buffer cleared, ser_out=IDLE_BIT, ser_valid=0, frame_start=0, busy=0, din_ready=0.
REQ-017 Reset asserted mid-word SHALL discard the partial word and the buffered word immediately, with no bits emitted after assertion.
REQ-018 The first cycle after reset deassertion SHALL have din_ready=1 and the block in IDLE.

Structure
REQ-019 A shared package SHALL hold the state enum (IDLE, SHIFT) and the default values of WIDTH, MSB_FIRST and IDLE_BIT.
REQ-020 The hold buffer SHALL be the sub-module ser_hold_buf: one entry, WIDTH data, with write, read and full signals.
REQ-021 The RTL SHALL have exactly one clock domain, and every flop SHALL use asynchronous reset on rst.

Verification
REQ-022 Single word: MSB_FIRST=1, 8'h92 accepted at edge N -> ser_out 1,0,0,1,0,0,1,0 on cycles N+1..N+8; frame_start only at N+1; ser_valid=0 and ser_out=0 at N+9.
REQ-023 Back-to-back: 8'hA5 then 8'h3C offered continuously -> 16 contiguous valid bits 10100101 00111100; frame_start at bits 1 and 9; din_ready low from the cycle after 8'h3C is accepted until the cycle after bit 8.
REQ-024 LSB first: MSB_FIRST=0, 8'h01 -> ser_out 1 then seven 0s.
REQ-025 Backpressure: hold din_valid=1 with three words 8'hFF, 8'h00, 8'hF0 -> all 24 bits emitted in order, with no word dropped or duplicated.
REQ-026 Mid-word reset: assert rst after 3 bits of 8'hC3 while 8'h81 is buffered -> ser_valid=0 and ser_out=IDLE_BIT immediately; after release, no 8'hC3 or 8'h81 bits appear and din_ready=1.
REQ-027 Idle level: IDLE_BIT=1 with no input -> ser_out=1 and ser_valid=0 for 20 cycles.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared types and parameter defaults for the bit serializer.
package bit_serializer_pkg;
  localparam int DEF_WIDTH     = 8;
  localparam bit DEF_MSB_FIRST = 1'b1;
  localparam bit DEF_IDLE_BIT  = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/ser_hold_buf.sv
// One-entry hold buffer that parks the next word while the shifter is busy.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);
  logic [WIDTH-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr) begin
      data <= wdata;
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

  assign rdata = data;
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer for gapless streaming.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = DEF_MSB_FIRST,
  parameter bit IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic             ser_out_nx, ser_valid_nx, frame_nx;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic             hold_full, hold_wr, hold_rd;
  logic [WIDTH-1:0] hold_data;
  logic             last, accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = ~hold_full & ~rst;
  assign accept    = din_valid & din_ready;
  assign last      = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  // Words arriving mid-word wait in the buffer; on the last bit the buffer drains first.
  assign hold_wr   = accept && (state == SHIFT) && !last;
  assign hold_rd   = last && hold_full;
  assign busy      = (state == SHIFT) || hold_full;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .wr    (hold_wr),
    .wdata (din),
    .rd    (hold_rd),
    .rdata (hold_data),
    .full  (hold_full)
  );

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sh_nx        = sh;
    ser_out_nx   = IDLE_BIT;
    ser_valid_nx = 1'b0;
    frame_nx     = 1'b0;
    load         = 1'b0;
    load_word    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          load_word = din;
        end
      end
      SHIFT: begin
        if (!last) begin
          cnt_nx       = cnt + CW'(1);
          ser_out_nx   = head(sh);
          sh_nx        = advance(sh);
          ser_valid_nx = 1'b1;
        end else if (hold_full) begin
          load      = 1'b1;
          load_word = hold_data;
        end else if (accept) begin
          load      = 1'b1;
          load_word = din;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // The first bit is registered out at the load edge; the shifter keeps the rest.
    if (load) begin
      state_nx     = SHIFT;
      cnt_nx       = '0;
      ser_out_nx   = head(load_word);
      sh_nx        = advance(load_word);
      ser_valid_nx = 1'b1;
      frame_nx     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sh          <= sh_nx;
      ser_out     <= ser_out_nx;
      ser_valid   <= ser_valid_nx;
      frame_start <= frame_nx;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Bench: three serializer variants on shared inputs, checked against a queue-based stream model.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         din_valid;
  logic [W-1:0] din;
  logic [2:0]   ser_out, ser_valid, frame_start, busy, din_ready;

  always #5 clk = ~clk;

  // 0: MSB first, idle 0   1: LSB first, idle 0   2: MSB first, idle 1
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .frame_start(frame_start[0]), .busy(busy[0]));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .frame_start(frame_start[1]), .busy(busy[1]));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_idl (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[2]),
    .ser_out(ser_out[2]), .ser_valid(ser_valid[2]), .frame_start(frame_start[2]), .busy(busy[2]));

  // Model: words waiting to start, the word being sent and how many of its bits remain.
  logic [W-1:0] pend[$];
  logic [W-1:0] acc_log[$];
  logic [W-1:0] cw;
  int           rem;
  bit           acc;
  logic [W-1:0] rx;
  int           rx_k;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    acc_log.delete();
    rem  = 0;
    cw   = '0;
    rx_k = 0;
    acc  = 1'b0;
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = !rst && (pend.size() == 0);
    acc = din_valid && rdy;
    if (rst) begin
      model_reset();
      return;
    end
    if (acc) begin
      pend.push_back(din);
      acc_log.push_back(din);
    end
    if (rem <= 1) begin
      if (pend.size() > 0) begin
        cw  = pend.pop_front();
        rem = W;
      end else begin
        rem = 0;
      end
    end else begin
      rem--;
    end
  endtask

  task automatic check_all();
    int       k;
    bit       v;
    bit       eb;
    logic [W-1:0] w;
    k = W - rem;
    v = (rem > 0);
    for (int i = 0; i < 3; i++) begin
      if (!v)          eb = (i == 2);
      else if (i == 1) eb = cw[k];
      else             eb = cw[W-1-k];
      chk($sformatf("ser_valid[%0d]", i),   32'(ser_valid[i]),   32'(v));
      chk($sformatf("ser_out[%0d]", i),     32'(ser_out[i]),     32'(eb));
      chk($sformatf("frame_start[%0d]", i), 32'(frame_start[i]), 32'(v && k == 0));
      chk($sformatf("busy[%0d]", i),        32'(busy[i]),        32'(v));
      chk($sformatf("din_ready[%0d]", i),   32'(din_ready[i]),   32'(!rst && pend.size() == 0));
    end
    // Reassemble MSB-first words to catch drops or duplicates across the whole stream.
    if (ser_valid[0] === 1'b1) begin
      if (frame_start[0] === 1'b1) rx_k = 0;
      rx = {rx[W-2:0], ser_out[0]};
      rx_k++;
      if (rx_k == W) begin
        w = (acc_log.size() > 0) ? acc_log.pop_front() : ~rx;
        chk("word_order", 32'(rx), 32'(w));
        rx_k = 0;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic offer(input logic [W-1:0] d);
    int t;
    t = 0;
    do begin
      cycle(1'b1, d);
      t++;
    end while (!acc && t < 64);
    chk("offer_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    rx        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    #1 check_all();

    // single word, then gapless pair
    offer(8'h92);
    idle(10);
    offer(8'hA5);
    offer(8'h3C);
    idle(20);

    // sustained backpressure with three words
    offer(8'hFF);
    offer(8'h00);
    offer(8'hF0);
    idle(30);

    offer(8'h01);
    idle(10);

    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 3) != 0, W'($urandom));
    idle(20);
    chk("all_words_out", 32'(acc_log.size()), 32'd0);

    // reset three bits into a word with another word buffered
    offer(8'hC3);
    offer(8'h81);
    cycle(1'b0, '0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    #1 check_all();
    idle(20);

    offer(8'h5A);
    idle(12);
    chk("final_drain", 32'(acc_log.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
